// File: rtl/module_1_clk_ctrl.sv
// Control stage ahead of the module_1 CRG: produces clk1_sel/clk1_en/clk3_en, sequences
// glitch-free clk1 source switches and holds all clocks gated until MMCM lock is stable.
module module_1_clk_ctrl #(
    parameter int GATE_CYC    = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int LOCK_STABLE = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk_ctrl,
    input  logic rst_clk_ctrl,
    input  logic mmcm_locked,
    input  logic clk1_run,
    input  logic clk3_run,
    input  logic sel_req_valid,
    input  logic sel_req_src,
    output logic sel_req_ready,
    output logic clk1_sel,
    output logic clk1_en,
    output logic clk3_en,
    output logic busy,
    output logic sel_done,
    output logic lock_lost
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if (GATE_CYC < 1 || GATE_CYC > CNT_MAX) begin : g_bad_gate
        $error("GATE_CYC out of range for CNT_W");
    end
    if (SETTLE_CYC < 1 || SETTLE_CYC > CNT_MAX) begin : g_bad_settle
        $error("SETTLE_CYC out of range for CNT_W");
    end
    if (LOCK_STABLE < 1 || LOCK_STABLE > CNT_MAX) begin : g_bad_lock
        $error("LOCK_STABLE out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RUN       = 3'd1,
        GATE_OFF  = 3'd2,
        SWITCH    = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    state_t           state;
    logic [1:0]       lock_sync;
    logic             locked_s;
    logic [CNT_W-1:0] cnt;
    logic             src_q;

    assign locked_s = lock_sync[1];

    always_ff @(posedge clk_ctrl) begin
        if (rst_clk_ctrl) begin
            state         <= WAIT_LOCK;
            lock_sync     <= '0;
            cnt           <= '0;
            src_q         <= 1'b0;
            sel_req_ready <= 1'b0;
            clk1_sel      <= 1'b0;
            clk1_en       <= 1'b0;
            clk3_en       <= 1'b0;
            busy          <= 1'b0;
            sel_done      <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[0], mmcm_locked};
            sel_done  <= 1'b0;
            lock_lost <= 1'b0;

            // Lock loss beats any in-flight switch; clk1_sel is deliberately left alone.
            if (state != WAIT_LOCK && !locked_s) begin
                state         <= WAIT_LOCK;
                cnt           <= '0;
                sel_req_ready <= 1'b0;
                clk1_en       <= 1'b0;
                clk3_en       <= 1'b0;
                busy          <= 1'b0;
                lock_lost     <= 1'b1;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        clk1_en       <= 1'b0;
                        clk3_en       <= 1'b0;
                        sel_req_ready <= 1'b0;
                        busy          <= 1'b0;
                        if (!locked_s) begin
                            cnt <= '0;
                        end else if (cnt == LOCK_LAST) begin
                            cnt           <= '0;
                            state         <= RUN;
                            sel_req_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end

                    RUN: begin
                        clk3_en <= clk3_run;
                        if (sel_req_valid && sel_req_ready && sel_req_src != clk1_sel) begin
                            src_q         <= sel_req_src;
                            clk1_en       <= 1'b0;
                            cnt           <= GATE_LD;
                            sel_req_ready <= 1'b0;
                            busy          <= 1'b1;
                            state         <= GATE_OFF;
                        end else begin
                            clk1_en <= clk1_run;
                            // Request for the source already selected completes immediately.
                            if (sel_req_valid && sel_req_ready) begin
                                sel_done <= 1'b1;
                            end
                        end
                    end

                    GATE_OFF: begin
                        clk1_en <= 1'b0;
                        clk3_en <= clk3_run;
                        if (cnt == '0) begin
                            clk1_sel <= src_q;
                            state    <= SWITCH;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end

                    SWITCH: begin
                        clk1_en <= 1'b0;
                        clk3_en <= clk3_run;
                        cnt     <= SETTLE_LD;
                        state   <= SETTLE;
                    end

                    SETTLE: begin
                        clk3_en <= clk3_run;
                        if (cnt == '0) begin
                            clk1_en       <= clk1_run;
                            sel_done      <= 1'b1;
                            sel_req_ready <= 1'b1;
                            busy          <= 1'b0;
                            state         <= RUN;
                        end else begin
                            clk1_en <= 1'b0;
                            cnt     <= cnt - CNT_W'(1);
                        end
                    end

                    default: begin
                        state         <= WAIT_LOCK;
                        cnt           <= '0;
                        sel_req_ready <= 1'b0;
                        clk1_en       <= 1'b0;
                        clk3_en       <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_module_1_clk_ctrl.sv
// Directed bench for module_1_clk_ctrl: lock-up, switch timing, same-source requests,
// requests while busy, lock loss mid-switch, clk3 tracking and reset mid-settle.
module tb_module_1_clk_ctrl;

    logic clk_ctrl = 1'b0;
    logic rst_clk_ctrl = 1'b1;
    logic mmcm_locked = 1'b0;
    logic clk1_run = 1'b0;
    logic clk3_run = 1'b0;
    logic sel_req_valid = 1'b0;
    logic sel_req_src = 1'b0;
    logic sel_req_ready, clk1_sel, clk1_en, clk3_en, busy, sel_done, lock_lost;

    int checks = 0;
    int failures = 0;

    always #5 clk_ctrl = ~clk_ctrl;

    module_1_clk_ctrl dut (
        .clk_ctrl      (clk_ctrl),
        .rst_clk_ctrl  (rst_clk_ctrl),
        .mmcm_locked   (mmcm_locked),
        .clk1_run      (clk1_run),
        .clk3_run      (clk3_run),
        .sel_req_valid (sel_req_valid),
        .sel_req_src   (sel_req_src),
        .sel_req_ready (sel_req_ready),
        .clk1_sel      (clk1_sel),
        .clk1_en       (clk1_en),
        .clk3_en       (clk3_en),
        .busy          (busy),
        .sel_done      (sel_done),
        .lock_lost     (lock_lost)
    );

    // Advance one active edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        tick();
        tick();
        got = {sel_req_ready, clk1_sel, clk1_en, clk3_en, busy, sel_done, lock_lost};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b exp 0000000", got);
        end
    endtask

    // Edge 0 is the first edge with reset low; enables rise after edge 18.
    task automatic test_lock_up();
        mmcm_locked = 1'b1;
        clk1_run = 1'b1;
        clk3_run = 1'b1;
        rst_clk_ctrl = 1'b0;
        for (int e = 0; e <= 17; e++) begin
            tick();
            checks++;
            if ({clk1_en, clk3_en} !== 2'b00) begin
                failures++;
                $display("FAIL lockup_en_edge%0d: got %b exp 00", e, {clk1_en, clk3_en});
            end
            checks++;
            if (sel_req_ready !== (e == 17)) begin
                failures++;
                $display("FAIL lockup_ready_edge%0d: got %b exp %b", e, sel_req_ready, (e == 17));
            end
        end
        tick();
        checks++;
        if ({clk1_en, clk3_en} !== 2'b11) begin
            failures++;
            $display("FAIL lockup_en_edge18: got %b exp 11", {clk1_en, clk3_en});
        end
    endtask

    // Accept at T0 with clk1_sel=0 -> sel flips at T0+4, en/sel_done at T0+13.
    task automatic test_switch();
        sel_req_valid = 1'b1;
        sel_req_src = 1'b1;
        tick();
        sel_req_valid = 1'b0;
        checks++;
        if ({clk1_en, busy, sel_req_ready, clk1_sel} !== 4'b0100) begin
            failures++;
            $display("FAIL switch_t0: got en,busy,rdy,sel=%b exp 0100",
                     {clk1_en, busy, sel_req_ready, clk1_sel});
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++;
            if (clk1_sel !== (k >= 4)) begin
                failures++;
                $display("FAIL switch_sel_t%0d: got %b exp %b", k, clk1_sel, (k >= 4));
            end
            checks++;
            if (clk1_en !== (k >= 13) || sel_done !== (k == 13) || busy !== (k < 13)) begin
                failures++;
                $display("FAIL switch_ctl_t%0d: got en,done,busy=%b%b%b exp %b%b%b", k,
                         clk1_en, sel_done, busy, (k >= 13), (k == 13), (k < 13));
            end
            checks++;
            if (clk3_en !== 1'b1) begin
                failures++;
                $display("FAIL switch_clk3_t%0d: got %b exp 1", k, clk3_en);
            end
        end
        tick();
        checks++;
        if (sel_done !== 1'b0) begin
            failures++;
            $display("FAIL switch_done_pulse: got %b exp 0", sel_done);
        end
    endtask

    // clk1_sel is 1 here; requesting 1 again completes without gating.
    task automatic test_same_src();
        sel_req_valid = 1'b1;
        sel_req_src = 1'b1;
        tick();
        sel_req_valid = 1'b0;
        checks++;
        if ({sel_done, clk1_en, busy, sel_req_ready} !== 4'b1101) begin
            failures++;
            $display("FAIL same_src_accept: got done,en,busy,rdy=%b exp 1101",
                     {sel_done, clk1_en, busy, sel_req_ready});
        end
        tick();
        checks++;
        if ({sel_done, clk1_en, busy, clk1_sel} !== 4'b0101) begin
            failures++;
            $display("FAIL same_src_after: got done,en,busy,sel=%b exp 0101",
                     {sel_done, clk1_en, busy, clk1_sel});
        end
    endtask

    // Valid held through a switch with a new src: only accepted once RUN resumes.
    task automatic test_back_to_back();
        sel_req_valid = 1'b1;
        sel_req_src = 1'b0;
        tick();
        sel_req_src = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (sel_req_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_busy_t%0d: got rdy,busy=%b%b exp 01", k, sel_req_ready, busy);
            end
        end
        tick();
        checks++;
        if ({sel_req_ready, busy, sel_done, clk1_sel, clk1_en} !== 5'b10101) begin
            failures++;
            $display("FAIL b2b_t13: got rdy,busy,done,sel,en=%b exp 10101",
                     {sel_req_ready, busy, sel_done, clk1_sel, clk1_en});
        end
        tick();
        sel_req_valid = 1'b0;
        checks++;
        if ({sel_req_ready, busy, sel_done, clk1_en} !== 4'b0100) begin
            failures++;
            $display("FAIL b2b_second_accept: got rdy,busy,done,en=%b exp 0100",
                     {sel_req_ready, busy, sel_done, clk1_en});
        end
        repeat (13) tick();
        checks++;
        if ({clk1_sel, clk1_en, sel_done, busy} !== 4'b1110) begin
            failures++;
            $display("FAIL b2b_second_done: got sel,en,done,busy=%b exp 1110",
                     {clk1_sel, clk1_en, sel_done, busy});
        end
    endtask

    // Lock drops in GATE_OFF; two sync stages put the abort at T0+4.
    task automatic test_lock_loss();
        sel_req_valid = 1'b1;
        sel_req_src = 1'b0;
        tick();
        sel_req_valid = 1'b0;
        tick();
        mmcm_locked = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            tick();
            checks++;
            if (lock_lost !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL lockloss_pre_t%0d: got lost,busy=%b%b exp 01", k, lock_lost, busy);
            end
        end
        tick();
        checks++;
        if ({lock_lost, clk1_en, clk3_en, clk1_sel, busy, sel_req_ready} !== 6'b100100) begin
            failures++;
            $display("FAIL lockloss_t4: got lost,en1,en3,sel,busy,rdy=%b exp 100100",
                     {lock_lost, clk1_en, clk3_en, clk1_sel, busy, sel_req_ready});
        end
        for (int k = 5; k <= 20; k++) begin
            tick();
            checks++;
            if (lock_lost !== 1'b0 || sel_done !== 1'b0 || clk1_sel !== 1'b1) begin
                failures++;
                $display("FAIL lockloss_hold_t%0d: got lost,done,sel=%b%b%b exp 001",
                         k, lock_lost, sel_done, clk1_sel);
            end
        end
        mmcm_locked = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick();
            checks++;
            if (sel_req_ready !== (e == 17) || clk1_en !== 1'b0) begin
                failures++;
                $display("FAIL relock_edge%0d: got rdy,en=%b%b exp %b0", e, sel_req_ready,
                         clk1_en, (e == 17));
            end
        end
        tick();
        checks++;
        if ({clk1_en, clk3_en, clk1_sel} !== 3'b111) begin
            failures++;
            $display("FAIL relock_run: got en1,en3,sel=%b exp 111", {clk1_en, clk3_en, clk1_sel});
        end
    endtask

    // clk3_en follows clk3_run during a switch, then reset lands mid-SETTLE.
    task automatic test_clk3_and_reset();
        logic exp3;
        logic [6:0] got;
        sel_req_valid = 1'b1;
        sel_req_src = 1'b0;
        tick();
        sel_req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp3 = (k % 2) == 1;
            clk3_run = exp3;
            tick();
            checks++;
            if (clk3_en !== exp3 || clk1_en !== 1'b0) begin
                failures++;
                $display("FAIL clk3_track_t%0d: got en3,en1=%b%b exp %b0", k, clk3_en, clk1_en, exp3);
            end
        end
        clk3_run = 1'b1;
        rst_clk_ctrl = 1'b1;
        tick();
        got = {sel_req_ready, clk1_sel, clk1_en, clk3_en, busy, sel_done, lock_lost};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_settle: got %b exp 0000000", got);
        end
        rst_clk_ctrl = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (sel_done !== 1'b0 || busy !== 1'b0 || clk1_sel !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_done_t%0d: got done,busy,sel=%b%b%b exp 000",
                         k, sel_done, busy, clk1_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_switch();
        test_same_src();
        test_back_to_back();
        test_lock_loss();
        test_clk3_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
